// File: rtl/generic_2clk_fifo_wr_arb.sv
// generic_2clk_fifo_wr_arb
// Round-robin packet arbiter in front of a FIFO write port. Four requesters
// compete. The winner holds the write port until it sends a beat flagged
// req_last, or until it reaches MAX_BEATS beats. An oversize packet is cut off
// at MAX_BEATS and raises the sticky len_err flag.
// Optional feature: define GENERIC_FIFO_WR_ARB_WMARK_EN to hold off new grants
// while the FIFO fill level (wr_entry_used) is at or above HI_WMARK.
module generic_2clk_fifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DAT_WIDTH = 36,
  parameter int PTR_WIDTH = 9,
  parameter int MAX_BEATS = 64,
  parameter int HI_WMARK  = 448
) (
  input  logic                         wr_clk,
  input  logic                         wr_reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DAT_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           gnt,
  input  logic                         wr_full,
  input  logic [PTR_WIDTH:0]           wr_entry_used,
  output logic                         wr_op,
  output logic [DAT_WIDTH-1:0]         wr_data,
  output logic [DAT_WIDTH-1:0]         wr_mask,
  output logic                         busy,
  output logic [1:0]                   winner,
  output logic                         len_err,
  input  logic                         len_err_clr
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       last_winner;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       rr_pick;
  logic             rr_found;
  logic             grant_ok;
  logic             accept;
  logic             at_max;
  logic             end_beat;
  logic             force_end;

`ifdef GENERIC_FIFO_WR_ARB_WMARK_EN
  // Hold off new grants while the FIFO is close to full.
  assign grant_ok = wr_entry_used < (PTR_WIDTH+1)'(HI_WMARK);
`else
  assign grant_ok = 1'b1;
  logic [PTR_WIDTH:0] unused_wmark;
  assign unused_wmark = wr_entry_used ^ (PTR_WIDTH+1)'(HI_WMARK);
`endif

  // Round-robin search. It starts at the requester after the last winner,
  // and the 2-bit addition wraps from 3 back to 0.
  always_comb begin
    // NOTE: both outputs get a default before the loop. Without it, this
    // block would infer a latch on the paths where no requester is found.
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!rr_found && req[last_winner + 2'(i)]) begin
        rr_pick  = last_winner + 2'(i);
        rr_found = 1'b1;
      end
    end
  end

  // Beat acceptance and end-of-packet detection for the granted requester.
  assign accept    = (state == BUSY) && req[winner] && !wr_full;
  assign at_max    = beat_cnt == CNT_W'(MAX_BEATS - 1);
  assign end_beat  = accept && (req_last[winner] || at_max);
  assign force_end = accept && !req_last[winner] && at_max;

  // The FIFO write port follows acceptance combinationally, with no extra
  // register stage.
  assign wr_op   = accept;
  assign wr_data = accept ? req_data[int'(winner)*DAT_WIDTH +: DAT_WIDTH] : '0;
  assign wr_mask = accept ? '1 : '0;

  // Arbiter FSM: grant in IDLE, then hold the grant until the packet ends.
  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      state       <= IDLE;
      gnt         <= '0;
      winner      <= '0;
      busy        <= 1'b0;
      beat_cnt    <= '0;
      last_winner <= 2'd3;
    end else begin
      // NOTE: non-blocking assignments. Every register here updates from the
      // values that were present before the clock edge.
      case (state)
        IDLE: begin
          if (rr_found && grant_ok) begin
            state    <= BUSY;
            gnt      <= NUM_REQ'(1) << rr_pick;
            winner   <= rr_pick;
            busy     <= 1'b1;
            beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (end_beat) begin
              state       <= IDLE;
              gnt         <= '0;
              busy        <= 1'b0;
              last_winner <= winner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky oversize flag. A new error wins over a clear in the same cycle.
  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset)         len_err <= 1'b0;
    else if (force_end)   len_err <= 1'b1;
    else if (len_err_clr) len_err <= 1'b0;
  end

endmodule

// File: tb/tb_generic_2clk_fifo_wr_arb.sv
// Testbench for generic_2clk_fifo_wr_arb.
// A transaction-level model checks every cycle. Directed scenarios add
// hand-computed expectations on grant order, write counts and error flags.
module tb_generic_2clk_fifo_wr_arb;

  localparam int DW  = 36;
  localparam int MAX = 64;
  localparam int HI  = 448;

  logic          wr_clk = 1'b0;
  logic          wr_reset;
  logic [3:0]    req;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_last;
  logic [3:0]    gnt;
  logic          wr_full;
  logic [9:0]    wr_entry_used;
  logic          wr_op;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] wr_mask;
  logic          busy;
  logic [1:0]    winner;
  logic          len_err;
  logic          len_err_clr;

  generic_2clk_fifo_wr_arb dut (
    .wr_clk(wr_clk), .wr_reset(wr_reset), .req(req), .req_data(req_data),
    .req_last(req_last), .gnt(gnt), .wr_full(wr_full),
    .wr_entry_used(wr_entry_used), .wr_op(wr_op), .wr_data(wr_data),
    .wr_mask(wr_mask), .busy(busy), .winner(winner), .len_err(len_err),
    .len_err_clr(len_err_clr)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packet-level view: who holds the port, how many beats it has sent,
  // who won last, and the sticky error flag.
  bit m_busy;
  int m_win;
  int m_last;
  int m_beats;
  bit m_lerr;

  function automatic int rr_next(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction

  logic wm_ok;
`ifdef GENERIC_FIFO_WR_ARB_WMARK_EN
  assign wm_ok = wr_entry_used < HI;
`else
  assign wm_ok = 1'b1;
`endif

  logic          m_accept;
  logic          m_over;
  logic [3:0]    exp_gnt;
  logic [DW-1:0] exp_data;
  assign m_accept = m_busy && req[m_win] && !wr_full;
  assign m_over   = m_accept && !req_last[m_win] && (m_beats + 1 == MAX);
  assign exp_gnt  = m_busy ? (4'b0001 << m_win) : 4'b0000;
  assign exp_data = m_accept ? req_data[m_win*DW +: DW] : '0;

  always @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      m_busy <= 0; m_win <= 0; m_last <= 3; m_beats <= 0; m_lerr <= 0;
    end else begin
      if (!m_busy) begin
        if (req != 4'b0 && wm_ok) begin
          m_win   <= rr_next(m_last, req);
          m_busy  <= 1;
          m_beats <= 0;
        end
      end else if (m_accept) begin
        m_beats <= m_beats + 1;
        if (req_last[m_win] || m_beats + 1 == MAX) begin
          m_busy <= 0;
          m_last <= m_win;
        end
      end
      if (m_over) m_lerr <= 1;
      else if (len_err_clr) m_lerr <= 0;
    end
  end

  // ---------------- per-cycle compare and event logs ----------------
  int  glog[$];
  bit  prev_busy = 0;
  int  op_cnt = 0;
  int  op2_cnt = 0;
  int  gnt2_cycles = 0;

  always @(negedge wr_clk) begin
    check("gnt",     gnt,     exp_gnt);
    check("winner",  winner,  m_win);
    check("busy",    busy,    m_busy);
    check("wr_op",   wr_op,   m_accept);
    check("wr_data", wr_data, exp_data);
    check("wr_mask", wr_mask, m_accept ? {DW{1'b1}} : {DW{1'b0}});
    check("len_err", len_err, m_lerr);
    if (busy && !prev_busy) glog.push_back(int'(winner));
    prev_busy <= busy;
    if (wr_op) op_cnt <= op_cnt + 1;
    if (wr_op && winner == 2'd2) op2_cnt <= op2_cnt + 1;
    if (gnt == 4'b0100) gnt2_cycles <= gnt2_cycles + 1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  int base_g;
  int base_op;
  int base_op2;
  int base_g2;

  initial begin
    wr_reset = 1; req = '0; req_last = '0; req_data = '0; wr_full = 0;
    wr_entry_used = '0; len_err_clr = 0;
    tick(); tick(); tick();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_winner", winner, 2'd0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_wr_op", wr_op, 1'b0);
    wr_reset = 0;

    // All four requesters send one 1-beat packet each.
    for (int i = 0; i < 4; i++) set_data(i, {4'(i + 1), 32'hC0DE_0000 + 32'(i)});
    base_g = glog.size(); base_op = op_cnt;
    req = 4'b1111; req_last = 4'b1111;
    repeat (8) tick();
    req = '0; req_last = '0;
    check("rr_grants", glog.size() - base_g, 4);
    if (glog.size() >= base_g + 4)
      for (int k = 0; k < 4; k++) check("rr_order", glog[base_g + k], k);
    check("rr_wr_ops", op_cnt - base_op, 4);

    // Requester 2 sends 3 beats and stalls on beat 2 for 5 cycles.
    // Requester 0 raises req mid-packet and is served afterwards.
    base_g = glog.size(); base_op2 = op2_cnt; base_g2 = gnt2_cycles;
    req = 4'b0100; set_data(2, 36'hA_0000_0001);
    tick();
    #1;
    check("beat1_data", wr_data, 36'hA_0000_0001);
    check("beat1_mask", wr_mask, 36'hF_FFFF_FFFF);
    req[0] = 1; req_last[0] = 1; set_data(0, 36'h5_0000_0000);
    tick();
    set_data(2, 36'hA_0000_0002); wr_full = 1;
    #1;
    check("full_no_op", wr_op, 1'b0);
    check("full_no_data", wr_data, 36'h0);
    repeat (5) tick();
    wr_full = 0;
    tick();
    set_data(2, 36'hA_0000_0003); req_last[2] = 1;
    tick();
    req[2] = 0; req_last[2] = 0;
    tick(); tick();
    req = '0; req_last = '0;
    check("stall_ops_r2", op2_cnt - base_op2, 3);
    check("stall_gnt2_cycles", gnt2_cycles - base_g2, 8);
    check("stall_grants", glog.size() - base_g, 2);
    if (glog.size() >= base_g + 2) begin
      check("stall_first", glog[base_g], 2);
      check("stall_next", glog[base_g + 1], 0);
    end

    // Requester 1 sends 80 beats without req_last in time.
    base_g = glog.size(); base_op = op_cnt;
    req = 4'b0010;
    tick();
    for (int b = 1; b <= 64; b++) begin set_data(1, 36'(b)); tick(); end
    check("oversize_len_err", len_err, 1'b1);
    check("oversize_released", busy, 1'b0);
    set_data(1, 36'd65);
    tick();
    for (int b = 65; b <= 80; b++) begin
      set_data(1, 36'(b)); req_last[1] = (b == 80); tick();
    end
    req = '0; req_last = '0;
    check("oversize_ops", op_cnt - base_op, 80);
    check("oversize_grants", glog.size() - base_g, 2);
    check("len_err_sticky", len_err, 1'b1);
    len_err_clr = 1; tick(); len_err_clr = 0;
    check("len_err_cleared", len_err, 1'b0);

    // Requester 3 overflows, and len_err_clr is high in the same cycle.
    req = 4'b1000;
    tick();
    for (int b = 1; b <= 64; b++) begin
      len_err_clr = (b == 64); set_data(3, 36'(b + 100)); tick();
    end
    len_err_clr = 0; req = '0;
    check("set_beats_clear", len_err, 1'b1);
    len_err_clr = 1; tick(); len_err_clr = 0;

    // Reset during beat 2 of a packet from requester 2.
    req = 4'b0100; set_data(2, 36'hB_0000_0001);
    tick(); tick();
    set_data(2, 36'hB_0000_0002);
    wr_reset = 1;
    #1;
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_wr_op", wr_op, 1'b0);
    tick(); tick();
    wr_reset = 0;
    base_g = glog.size();
    req = 4'b0101; req_last = 4'b0101;
    tick(); tick();
    req = '0; req_last = '0;
    check("post_rst_grants", glog.size() - base_g, 1);
    if (glog.size() >= base_g + 1) check("post_rst_first", glog[base_g], 0);

    // Watermark behaviour for requester 0.
    wr_entry_used = 10'd448; req = 4'b0001; req_last = 4'b0001;
`ifdef GENERIC_FIFO_WR_ARB_WMARK_EN
    tick(); tick(); tick();
    check("wmark_hold", gnt, 4'b0000);
    wr_entry_used = 10'd447;
    tick();
    check("wmark_release", gnt, 4'b0001);
`else
    tick();
    check("wmark_ignored", gnt, 4'b0001);
`endif
    tick();
    req = '0; req_last = '0; wr_entry_used = '0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
